// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared reservation-station tag type and ALU opcode encoding
package cpu_types;

  localparam int TAG_W = 5;

  typedef logic [TAG_W-1:0] RS_tag_type;

  // All-ones tag marks "no result on the bus"; real tags stay below it.
  localparam RS_tag_type INVALID = '1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_COPY = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_SRA  = 4'd13
  } alu_op_e;

endpackage

// File: rtl/fu_result_fifo.sv
// rtl/fu_result_fifo.sv - result queue with two write ports and one read port
module fu_result_fifo
  import cpu_types::*;
#(
  parameter int WIDTH      = 32,
  parameter int OUTQ_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  // port 0 carries the older result and always lands in the lower slot
  input  logic                          s0_tvalid_i,
  input  logic [WIDTH-1:0]              s0_tdata_i,
  input  RS_tag_type                    s0_tuser_i,
  input  logic                          s1_tvalid_i,
  input  logic [WIDTH-1:0]              s1_tdata_i,
  input  RS_tag_type                    s1_tuser_i,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic [WIDTH-1:0]              m_tdata_o,
  output RS_tag_type                    m_tuser_o,
  output logic [$clog2(OUTQ_DEPTH):0]   count_o
);

  localparam int AW = $clog2(OUTQ_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] data_mem [OUTQ_DEPTH];
  RS_tag_type       tag_mem  [OUTQ_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr1_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  // Upstream credit guarantees room for both writes, so no full check here.
  assign pop     = m_tready_i && (count_q != '0);
  assign wr1_ptr = wr_ptr_q + AW'(s0_tvalid_i);

  // Pointer and occupancy update; flush empties the queue and wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(s0_tvalid_i) + AW'(s1_tvalid_i);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(s0_tvalid_i) + CW'(s1_tvalid_i) - CW'(pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (s0_tvalid_i) begin
        data_mem[wr_ptr_q] <= s0_tdata_i;
        tag_mem[wr_ptr_q]  <= s0_tuser_i;
      end
      if (s1_tvalid_i) begin
        data_mem[wr1_ptr] <= s1_tdata_i;
        tag_mem[wr1_ptr]  <= s1_tuser_i;
      end
    end
  end

  assign m_tvalid_o = (count_q != '0);
  assign m_tdata_o  = m_tvalid_o ? data_mem[rd_ptr_q] : '0;
  assign m_tuser_o  = m_tvalid_o ? tag_mem[rd_ptr_q] : INVALID;
  assign count_o    = count_q;

endmodule

// File: rtl/alu_fu_pipe.sv
// rtl/alu_fu_pipe.sv - integer ALU functional unit with pipelined multiplier and CDB result queue
module alu_fu_pipe
  import cpu_types::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_LAT    = 3,
  parameter int OUTQ_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] V1,
  input  logic [WIDTH-1:0] V2,
  input  logic [3:0]       alu_fun,
  input  RS_tag_type       rd_tag,
  output logic             CDB_req,
  input  logic             CDB_grant,
  output logic [WIDTH-1:0] CDB_val,
  output RS_tag_type       CDB_tag
);

  localparam int NSTG = MUL_LAT - 1;
  localparam int SHW  = $clog2(WIDTH);
  localparam int QCW  = $clog2(OUTQ_DEPTH) + 1;
  localparam int CW   = $clog2(OUTQ_DEPTH + MUL_LAT) + 1;

  logic             fire;
  logic             is_mul;
  logic             fast_wr;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_res;
  logic [QCW-1:0]   q_count;
  logic [CW-1:0]    inflight;

  logic             mul_vld_q [NSTG];
  RS_tag_type       mul_tag_q [NSTG];
  logic [WIDTH-1:0] mul_val_q [NSTG];

  assign fire    = issue_valid && issue_ready;
  assign is_mul  = (alu_fun == ALU_MUL);
  assign fast_wr = fire && !is_mul && !flush;
  assign shamt   = V2[SHW-1:0];

  // Count multiplies still travelling down the lane; each owns a future queue slot.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < NSTG; k++) begin
      inflight = inflight + CW'(mul_vld_q[k]);
    end
  end

  // Credit from registered state only, so a same-cycle pop never admits an issue.
  assign issue_ready = !RST && ((CW'(q_count) + inflight) < CW'(OUTQ_DEPTH));

  // Single-cycle ALU for every opcode except multiply.
  always_comb begin
    fast_res = '0;
    case (alu_fun)
      ALU_ADD:  fast_res = V1 + V2;
      ALU_SUB:  fast_res = V1 - V2;
      ALU_OR:   fast_res = V1 | V2;
      ALU_AND:  fast_res = V1 & V2;
      ALU_XOR:  fast_res = V1 ^ V2;
      ALU_SLL:  fast_res = V1 << shamt;
      ALU_SRL:  fast_res = V1 >> shamt;
      ALU_SRA:  fast_res = $unsigned($signed(V1) >>> shamt);
      ALU_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(V1) < $signed(V2))};
      ALU_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (V1 < V2)};
      ALU_COPY: fast_res = V1;
      default:  fast_res = '0;
    endcase
  end

  // Multiply lane: product formed on entry, then carried through the stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NSTG; k++) begin
        mul_vld_q[k] <= 1'b0;
        mul_tag_q[k] <= INVALID;
        mul_val_q[k] <= '0;
      end
    end else begin
      mul_vld_q[0] <= fire && is_mul && !flush;
      mul_tag_q[0] <= rd_tag;
      mul_val_q[0] <= V1 * V2;
      for (int k = 1; k < NSTG; k++) begin
        mul_vld_q[k] <= mul_vld_q[k-1] && !flush;
        mul_tag_q[k] <= mul_tag_q[k-1];
        mul_val_q[k] <= mul_val_q[k-1];
      end
    end
  end

  fu_result_fifo #(
    .WIDTH      (WIDTH),
    .OUTQ_DEPTH (OUTQ_DEPTH)
  ) u_result_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .flush_i     (flush),
    .s0_tvalid_i (mul_vld_q[NSTG-1]),
    .s0_tdata_i  (mul_val_q[NSTG-1]),
    .s0_tuser_i  (mul_tag_q[NSTG-1]),
    .s1_tvalid_i (fast_wr),
    .s1_tdata_i  (fast_res),
    .s1_tuser_i  (rd_tag),
    .m_tvalid_o  (CDB_req),
    .m_tready_i  (CDB_grant),
    .m_tdata_o   (CDB_val),
    .m_tuser_o   (CDB_tag),
    .count_o     (q_count)
  );

endmodule

// File: tb/tb_alu_fu_pipe.sv
// tb/tb_alu_fu_pipe.sv - directed self-checking bench for alu_fu_pipe
module tb_alu_fu_pipe;
  import cpu_types::*;

  localparam int WIDTH      = 32;
  localparam int MUL_LAT    = 3;
  localparam int OUTQ_DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [WIDTH-1:0] V1;
  logic [WIDTH-1:0] V2;
  logic [3:0]       alu_fun;
  RS_tag_type       rd_tag;
  logic             CDB_req;
  logic             CDB_grant;
  logic [WIDTH-1:0] CDB_val;
  RS_tag_type       CDB_tag;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [13];

  always #5 CLK = ~CLK;

  alu_fu_pipe #(
    .WIDTH      (WIDTH),
    .MUL_LAT    (MUL_LAT),
    .OUTQ_DEPTH (OUTQ_DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .V1          (V1),
    .V2          (V2),
    .alu_fun     (alu_fun),
    .rd_tag      (rd_tag),
    .CDB_req     (CDB_req),
    .CDB_grant   (CDB_grant),
    .CDB_val     (CDB_val),
    .CDB_tag     (CDB_tag)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input RS_tag_type t);
    issue_valid = 1'b1;
    alu_fun     = op;
    V1          = a;
    V2          = b;
    rd_tag      = t;
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    logic seen;

    vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
    vecs[1]  = '{ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE};
    vecs[2]  = '{ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
    vecs[3]  = '{ALU_AND,  32'h0000_0FF0, 32'h0000_00FF, 32'h0000_00F0};
    vecs[4]  = '{ALU_XOR,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0};
    vecs[5]  = '{ALU_SLL,  32'd1,         32'd33,        32'h0000_0002};
    vecs[6]  = '{ALU_SRL,  32'h8000_0000, 32'd31,        32'h0000_0001};
    vecs[7]  = '{ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[8]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001};
    vecs[9]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
    vecs[10] = '{ALU_COPY, 32'h0000_1234, 32'd99,        32'h0000_1234};
    vecs[11] = '{4'd15,    32'd5,         32'd5,         32'h0000_0000};
    vecs[12] = '{4'd11,    32'd5,         32'd5,         32'h0000_0000};

    RST         = 1'b1;
    flush       = 1'b0;
    issue_valid = 1'b0;
    CDB_grant   = 1'b0;
    V1          = '0;
    V2          = '0;
    alu_fun     = '0;
    rd_tag      = '0;

    // reset values
    repeat (2) @(negedge CLK);
    chk("rst_req",   CDB_req,     0);
    chk("rst_tag",   CDB_tag,     INVALID);
    chk("rst_val",   CDB_val,     0);
    chk("rst_ready", issue_ready, 0);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", issue_ready, 1);
    @(negedge CLK);

    // add 5+7 tag 3, grant held high
    CDB_grant = 1'b1;
    drive_issue(ALU_ADD, 32'd5, 32'd7, 5'd3);
    chk("add_req", CDB_req, 1);
    chk("add_val", CDB_val, 12);
    chk("add_tag", CDB_tag, 3);
    step();
    chk("add_popped", CDB_req, 0);

    // mul and sub land in the same cycle; mul is older
    CDB_grant = 1'b0;
    drive_issue(ALU_MUL, 32'd6, 32'd7, 5'd1);
    repeat (MUL_LAT - 2) step();
    chk("mul_not_early", CDB_req, 0);
    drive_issue(ALU_SUB, 32'd10, 32'd3, 5'd2);
    chk("dual_head0_val", CDB_val, 42);
    chk("dual_head0_tag", CDB_tag, 1);
    CDB_grant = 1'b1;
    step();
    chk("dual_head1_val", CDB_val, 7);
    chk("dual_head1_tag", CDB_tag, 2);
    step();
    chk("dual_empty", CDB_req, 0);
    CDB_grant = 1'b0;

    // fill the queue, back-pressure, one grant returns one credit
    for (int i = 0; i < OUTQ_DEPTH; i++) begin
      chk($sformatf("fill_ready%0d", i), issue_ready, 1);
      drive_issue(ALU_ADD, 32'(i), 32'd100, RS_tag_type'(4 + i));
    end
    chk("full_ready", issue_ready, 0);
    chk("full_head_val", CDB_val, 100);
    issue_valid = 1'b1;
    alu_fun     = ALU_ADD;
    V1          = 32'd50;
    V2          = 32'd50;
    rd_tag      = 5'd9;
    step();
    issue_valid = 1'b0;
    chk("hold_val", CDB_val, 100);
    chk("hold_tag", CDB_tag, 4);
    chk("hold_ready", issue_ready, 0);
    CDB_grant = 1'b1;
    step();
    CDB_grant = 1'b0;
    chk("credit_ready", issue_ready, 1);
    CDB_grant = 1'b1;
    for (int i = 1; i < OUTQ_DEPTH; i++) begin
      chk($sformatf("drain_val%0d", i), CDB_val, 100 + i);
      chk($sformatf("drain_tag%0d", i), CDB_tag, 4 + i);
      step();
    end
    chk("drain_empty", CDB_req, 0);
    chk("drain_empty_tag", CDB_tag, INVALID);

    // opcode table, grant high, one op per cycle
    for (int i = 0; i < 13; i++) begin
      drive_issue(vecs[i].op, vecs[i].a, vecs[i].b, RS_tag_type'(i + 1));
      chk($sformatf("op%0d_val", vecs[i].op), CDB_val, vecs[i].r);
      chk($sformatf("op%0d_tag", vecs[i].op), CDB_tag, i + 1);
    end
    step();
    chk("ops_empty", CDB_req, 0);

    // back-to-back multiplies retire on consecutive cycles
    drive_issue(ALU_MUL, 32'd3, 32'd4, 5'd20);
    drive_issue(ALU_MUL, 32'hFFFF_FFFF, 32'd2, 5'd21);
    drive_issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000, 5'd22);
    w = 0;
    while (!CDB_req && w < 20) begin
      step();
      w++;
    end
    chk("mul_seen", CDB_req, 1);
    chk("mul_latency", w, MUL_LAT - 3);
    chk("mul0_val", CDB_val, 12);
    chk("mul0_tag", CDB_tag, 20);
    step();
    chk("mul1_val", CDB_val, 32'hFFFF_FFFE);
    chk("mul1_tag", CDB_tag, 21);
    step();
    chk("mul2_val", CDB_val, 0);
    chk("mul2_tag", CDB_tag, 22);
    step();
    chk("mul_empty", CDB_req, 0);

    // flush with one queued result and multiplies in flight
    CDB_grant = 1'b0;
    drive_issue(ALU_ADD, 32'd1, 32'd1, 5'd10);
    drive_issue(ALU_MUL, 32'd2, 32'd2, 5'd11);
    drive_issue(ALU_MUL, 32'd3, 32'd3, 5'd12);
    chk("pre_flush_req", CDB_req, 1);
    chk("pre_flush_ready", issue_ready, 1);
    flush       = 1'b1;
    issue_valid = 1'b1;
    alu_fun     = ALU_MUL;
    V1          = 32'd4;
    V2          = 32'd4;
    rd_tag      = 5'd13;
    step();
    flush       = 1'b0;
    issue_valid = 1'b0;
    chk("flush_req", CDB_req, 0);
    chk("flush_tag", CDB_tag, INVALID);
    chk("flush_ready", issue_ready, 1);
    CDB_grant = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      if (CDB_req) seen = 1'b1;
      step();
    end
    chk("flush_no_late", seen, 0);
    drive_issue(ALU_ADD, 32'd2, 32'd2, 5'd14);
    chk("post_flush_val", CDB_val, 4);
    chk("post_flush_tag", CDB_tag, 14);
    step();

    // asynchronous reset mid-multiply
    CDB_grant = 1'b0;
    drive_issue(ALU_ADD, 32'd9, 32'd9, 5'd15);
    drive_issue(ALU_MUL, 32'd5, 32'd5, 5'd16);
    chk("pre_rst_req", CDB_req, 1);
    chk("pre_rst_val", CDB_val, 18);
    RST = 1'b1;
    #1;
    chk("arst_req",   CDB_req,     0);
    chk("arst_tag",   CDB_tag,     INVALID);
    chk("arst_val",   CDB_val,     0);
    chk("arst_ready", issue_ready, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("arst_ready_after", issue_ready, 1);
    @(negedge CLK);
    CDB_grant = 1'b1;
    seen = 1'b0;
    repeat (MUL_LAT + 2) begin
      if (CDB_req) seen = 1'b1;
      step();
    end
    chk("arst_no_late", seen, 0);
    drive_issue(ALU_ADD, 32'd1, 32'd1, 5'd17);
    chk("post_rst_val", CDB_val, 2);
    chk("post_rst_tag", CDB_tag, 17);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_fu_pipe.md
ALU_FU_PIPE -- requirements
Module: alu_fu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width.
REQ-002 Parameter MUL_LAT, default 3, multiply latency in cycles, legal range 2..8.
REQ-003 Parameter OUTQ_DEPTH, default 4, result queue entries, power of two, at least 2.
REQ-004 CLK input 1: single clock; all state updates on the rising edge.
REQ-005 RST input 1: asynchronous, active-high reset.
REQ-006 flush input 1: synchronous squash of all in-flight and queued results.
REQ-007 issue_valid input 1: reservation station presents an operation.
REQ-008 issue_ready output 1: unit accepts the operation this cycle.
REQ-009 V1, V2 input WIDTH: source operands, both already valid when issue_valid is high.
REQ-010 alu_fun input 4: operation code.
REQ-011 rd_tag input RS_tag_type: destination tag.
REQ-012 CDB_req output 1: head result is available for broadcast.
REQ-013 CDB_grant input 1: arbiter accepts the head result this cycle.
REQ-014 CDB_val output WIDTH: head result value.
REQ-015 CDB_tag output RS_tag_type: head tag, INVALID when CDB_req is low.

Function
REQ-016 Issue SHALL occur when issue_valid and issue_ready are high in the same cycle.
REQ-017 Opcodes: 0 add; 8 sub; 6 or; 7 and; 4 xor; 1 sll; 5 srl; 13 sra; 2 slt (signed); 3 sltu.
REQ-018 Opcodes continued: 9 copy V1; 10 mul low WIDTH bits; any other code yields 0 with its tag still broadcast.
REQ-019 Shift amount SHALL be V2[$clog2(WIDTH)-1:0]; all arithmetic is modulo 2^WIDTH.
REQ-020 Fast lane (every opcode except 10): issued in cycle N, written to the queue at the end of N, visible at the queue head no earlier than N+1.
REQ-021 Mul lane: MUL_LAT-1 register stages, each holding valid, tag and partial or full product; issued in N, written to the queue at the end of N+MUL_LAT-1.
REQ-022 The mul lane SHALL accept one new multiply every cycle (fully pipelined).
REQ-023 Result queue: FIFO with two write ports and one read port; same-cycle push and pop allowed.
REQ-024 Same-cycle writes from both lanes: mul result takes the lower FIFO slot (older issue), fast result the next slot.
REQ-025 issue_ready = (queue_count + mul_inflight) < OUTQ_DEPTH, computed from registered state only; a pop in the same cycle does not add credit.
REQ-026 The queue SHALL never overflow; a result is never dropped except by flush or RST.
REQ-027 CDB_req = queue non-empty; CDB_val and CDB_tag come from the head entry; CDB_tag = INVALID when the queue is empty.
REQ-028 A pop SHALL occur only when CDB_req and CDB_grant are both high; CDB_grant with an empty queue is ignored.
REQ-029 With CDB_grant held low, CDB_val and CDB_tag SHALL stay stable.
REQ-030 Queue and read/write pointers wrap modulo OUTQ_DEPTH.
REQ-031 flush: at the next edge, clear all mul-lane valids and empty the queue; an issue in the flush cycle is discarded.
REQ-032 flush has priority over a simultaneous issue, grant or lane write.

Reset
REQ-033 While RST is high: queue empty, all lane valids 0, CDB_req 0, CDB_tag INVALID, CDB_val 0, issue_ready 0.
REQ-034 issue_ready SHALL be 1 in the first cycle after RST deasserts.
REQ-035 RST asserted mid-operation discards all in-flight and queued results immediately, without waiting for a clock edge.

Structure
REQ-036 RS_tag_type, INVALID and the opcode enumeration SHALL live in cpu_types.
REQ-037 The result queue SHALL be a sub-module, fu_result_fifo, parametrised by WIDTH and OUTQ_DEPTH, with two write ports.

Verification
REQ-038 Scenario: issue add 5+7 with tag 3, grant held high -> CDB_req high one cycle later with CDB_val=12, CDB_tag=3.
REQ-039 Scenario: mul 6*7 with tag 1 at N, then sub 10-3 with tag 2 at N+MUL_LAT-1 -> same-cycle lane write; head shows 42/tag 1, then 7/tag 2.
REQ-040 Scenario: grant low, issue OUTQ_DEPTH fast ops -> issue_ready 0 after the fourth issue; one grant -> issue_ready 1 on the following cycle.
REQ-041 Scenario: 3 multiplies in flight plus 1 queued, flush -> next cycle CDB_req 0, CDB_tag INVALID, no later broadcast of those tags.
REQ-042 Scenario: sra of 0x80000000 by 4 -> 0xF8000000; slt(-1,1)=1; sltu(-1,1)=0; opcode 15 -> 0 with its tag.
REQ-043 Scenario: RST asserted mid-multiply -> outputs take their reset values asynchronously; post-reset issue of add 1+1 returns 2.
